// File: rtl/seg_pkg.sv
// Shared constants for the scanned 7-segment display path:
// active-low segment patterns, digit counts and FSM states.
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_DIGITS = 5;

    // {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        ST_IDLE,
        ST_CONV
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per clock, 16 shifts per value.
// o_bcd holds the last finished result and changes only with o_done.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_bin,
    output logic        o_busy,
    output logic        o_done,
    output logic [19:0] o_bcd
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_bin;
    logic [19:0] r_acc;
    logic [19:0] r_res;
    logic [4:0]  r_cnt;
    logic        r_done;
    logic [19:0] w_adj;
    logic [19:0] w_acc_nxt;
    logic        w_last;

    assign w_last = (r_state == ST_CONV) && (r_cnt == 5'd15);

    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_acc[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
        end
    end

    assign w_acc_nxt = {w_adj[18:0], r_bin[15]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_CONV;
            ST_CONV: if (w_last)  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bin  <= '0;
            r_acc  <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (r_state == ST_IDLE) begin
                if (i_start) begin
                    r_bin <= i_bin;
                    r_acc <= '0;
                    r_cnt <= '0;
                end
            end else begin
                r_bin <= {r_bin[14:0], 1'b0};
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 5'd1;
                if (w_last)
                    r_res <= w_acc_nxt;
            end
        end
    end

    assign o_busy = (r_state == ST_CONV);
    assign o_done = r_done;
    assign o_bcd  = r_res;

endmodule

// File: rtl/seg_scan_display.sv
// 4-digit multiplexed common-anode display fed by a sequential BCD converter.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int WIDTH    = 16
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf,
    output logic [6:0]       o_seg,
    output logic [3:0]       o_dig_sel
);

    localparam int            CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic                  w_busy;
    logic                  w_done;
    logic [19:0]           w_bcd;
    logic [CW-1:0]         r_scan;
    logic [1:0]            r_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic [3:0]            w_digit;
    logic                  w_blank;
    logic                  w_ovf;
    logic [6:0]            w_seg;

    // the converter's result register is the display store
    bin2bcd_seq u_conv (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_load),
        .i_bin   (i_value),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // a nonzero fifth digit means the value is above 9999
    assign w_ovf   = (w_bcd[19:16] != 4'd0);
    assign w_digit = w_bcd[{r_idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        unique case (r_idx)
            2'd3:    w_blank = (w_bcd[15:12] == 4'd0);
            2'd2:    w_blank = (w_bcd[15:8] == 8'd0);
            2'd1:    w_blank = (w_bcd[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    assign w_seg = w_ovf   ? SEG_DASH  :
                   w_blank ? SEG_BLANK :
                   seg_decode(w_digit);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_seg  <= SEG_0;
            r_dig  <= 4'b1110;
        end else begin
            if (r_scan == CNT_MAX) begin
                r_scan <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_scan <= r_scan + CW'(1);
            end
            r_seg <= w_seg;
            r_dig <= ~(4'b0001 << r_idx);
        end
    end

    assign o_busy    = w_busy;
    assign o_done    = w_done;
    assign o_ovf     = w_ovf;
    assign o_seg     = r_seg;
    assign o_dig_sel = r_dig;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4.
// Expected segment patterns are hand-written per vector.
module tb_seg_scan_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z  = 7'b1111111;
`else
    localparam logic [6:0] Z  = 7'b1000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    int n_cmp = 0;
    int n_bad = 0;

    seg_scan_display #(
        .SCAN_DIV (4),
        .WIDTH    (16)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_load    (load),
        .i_value   (value),
        .o_busy    (busy),
        .o_done    (done),
        .o_ovf     (ovf),
        .o_seg     (seg),
        .o_dig_sel (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", tag, got, exp);
        end
    endtask

    task automatic run_load(input logic [15:0] v, input string tag);
        int lat;
        int bc;
        @(negedge clk);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load = 1'b0;
        lat  = 1;
        bc   = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 17);
        chk({tag, "_busycyc"}, bc, 16);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    endtask

    task automatic rd_digits(input string tag, input logic [27:0] exp);
        logic [3:0] sel;
        int n;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sel = ~(4'b0001 << k);
            n   = 0;
            while (dig_sel !== sel && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20)
                chk($sformatf("%s_sel%0d_timeout", tag, k), dig_sel, sel);
            else
                chk($sformatf("%s_d%0d", tag, k), seg, exp[k*7 +: 7]);
        end
    endtask

    initial begin
        int ndone;
        int lat;
        logic [3:0] sel;
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_seg", seg, S0);
        chk("rst_dig", dig_sel, 4'b1110);

        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            sel = ~(4'b0001 << ((k - 1) / 4));
            chk($sformatf("scan_dig%0d", k), dig_sel, sel);
            chk($sformatf("scan_seg%0d", k), seg, (k <= 4) ? S0 : Z);
        end

        run_load(16'd33, "v33");
        chk("v33_ovf", ovf, 0);
        @(negedge clk);
        chk("v33_done_pulse", done, 0);
        rd_digits("v33", {Z, Z, S3, S3});

        run_load(16'd1234, "v1234");
        rd_digits("v1234", {S1, S2, S3, S4});

        run_load(16'd65535, "v65535");
        chk("v65535_ovf", ovf, 1);
        rd_digits("v65535", {SD, SD, SD, SD});

        run_load(16'd257, "v257");
        chk("v257_ovf", ovf, 0);
        rd_digits("v257", {Z, S2, S5, S7});

        // second load 3 cycles into a conversion is dropped
        @(negedge clk);
        load  = 1'b1;
        value = 16'd7;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        load  = 1'b1;
        value = 16'd9;
        @(negedge clk);
        load = 1'b0;
        lat  = 4;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("drop_lat", lat, 17);
        load  = 1'b1;
        value = 16'd9;
        @(negedge clk);
        load = 1'b0;
        chk("doneload_busy", busy, 1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("doneload_lat", lat, 17);
        rd_digits("v9", {Z, Z, Z, S9});

        run_load(16'd7, "v7");
        rd_digits("v7", {Z, Z, Z, S7});

        // reset on the 8th conversion cycle
        @(negedge clk);
        load  = 1'b1;
        value = 16'd4321;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_dig", dig_sel, 4'b1110);
        chk("abort_seg", seg, S0);
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        rd_digits("abort", {Z, Z, Z, S0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the 16-bit combinational divider's quotient output.
- Captures a 16-bit binary result on a load strobe and converts it to BCD sequentially (double-dabble, one bit per cycle).
- Drives a 4-digit multiplexed common-anode 7-segment display, replacing the static per-digit LED encoder on the board path.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz digit rate at 50 MHz); legal range >= 2.
- WIDTH, 16, binary input width; the design is verified only at 16.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  one-cycle strobe: capture value and start conversion.
- value  in  16  unsigned binary to display, e.g. divider quotient y.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the display registers have been updated.
- ovf  out  1  high while the displayed value exceeds 9999.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dig_sel  out  4  digit anodes, active-low one-hot; bit0 is the ones digit.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low (rst_n, sampled on the rising edge of clk).
- Reset values:
  - busy=0, done=0, ovf=0.
  - Display BCD registers = 0, digit index = 0, scan counter = 0.
  - dig_sel=4'b1110, seg=7'b1000000 (shows "0").
- FSM states: IDLE and CONV.
  - IDLE: if load is sampled at edge N, latch value, clear the 20-bit BCD accumulator, enter CONV, set busy=1 from cycle N+1.
  - CONV: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd,bin} left by 1. A 5-bit bit counter counts 16 shifts.
  - After the 16th shift (edge N+16):
    - Copy the 5 BCD digits to the display registers.
    - ovf = (digit4 != 0) || (value > 9999).
    - Return to IDLE; done=1 and busy=0 during cycle N+17.
- Handshake:
  - load while busy=1 is ignored; no queuing, and the value is lost.
  - load in the same cycle as done=1 is accepted.
- The display registers change only at the done edge. The old value stays on the display throughout a conversion.
- Scanning:
  - The scan counter runs 0..SCAN_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0->1->2->3->0.
  - dig_sel = ~(1<<index); seg = decode(display digit[index]).
  - seg and dig_sel are registered, so both change on the same edge, one cycle after the index changes.
- Overflow: while ovf=1, all four digits show '-' (seg=7'b0111111).
- Decode table (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other code shows blank (1111111).
- Reset mid-conversion: abort immediately and restore all reset values; no done pulse is produced.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: zero digits above the most significant nonzero digit show blank (1111111). The ones digit is never blanked. Example: value 33 shows "  33".
- Undefined: all four digits are always driven. Example: value 33 shows "0033".
- Overflow display is identical in both builds.

Decomposition:
- Package seg_pkg:
  - SEG_* localparams for the digit patterns, SEG_BLANK and SEG_DASH.
  - NUM_DIGITS=4, BCD_DIGITS=5.
  - FSM state encoding (ST_IDLE, ST_CONV).
- Sub-module bin2bcd_seq: the double-dabble engine.
  - Inputs: clk, rst_n, start, bin[15:0].
  - Outputs: busy, done, bcd[19:0].
  - The top level keeps the display registers, scan counter, decode and overflow logic.

Test Plan (tb uses SCAN_DIV=4):
- Reset, then release with no load -> seg=1000000, dig_sel cycles 1110,1101,1011,0111 every 4 clks; digits 1-3 show "0" (blank with SEG_LEADING_ZERO_BLANK_EN).
- load value=33 (100/3) -> busy high 16 cycles; done pulse 17 cycles after the load edge; digit0 seg=0110000, digit1 seg=0110000, ovf=0.
- load value=1234 -> digits 3..0 show 1,2,3,4 (1111001, 0100100, 0110000, 0011001).
- load value=65535 -> ovf=1, all digits 0111111; then load value=257 (65535/255) -> ovf=0, digits show 0257.
- load value=7 followed by a second load of 9 three cycles later -> second load ignored, display shows 7; a load of 9 issued in the done cycle is accepted and shows 9.
- Assert rst_n=0 at cycle 8 of a conversion -> no done pulse; busy=0, display "0", dig_sel=1110 on the next edge.
